// File: rtl/mod13_ctrl_pkg.sv
// mod13_ctrl_pkg: shared opcode/state types and the mod-13 wrap limit.
package mod13_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_HOLD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] MOD_MAX = 4'd12;

endpackage

// File: rtl/mod13_step_counter.sv
// mod13_step_counter: enabled mod-13 up/down counter with synchronous load.
// Ports: clk, rst_n (async active-low), en (step enable), load (priority over en),
//        mode (0 up, 1 down), data_in[3:0] (load value), count[3:0] (current value).
// Out-of-range values (13..15) only arise from an unchecked load: up steps then
// increment plainly (15 wraps to 0) and down steps decrement plainly.
module mod13_step_counter
    import mod13_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic       mode,
    input  logic [3:0] data_in,
    output logic [3:0] count
);

    logic [3:0] up_val;
    logic [3:0] down_val;

    always_comb begin
        up_val   = (count == MOD_MAX) ? 4'd0 : count + 4'd1;
        down_val = (count == 4'd0) ? MOD_MAX : count - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= 4'd0;
        else if (load)
            count <= data_in;
        else if (en)
            count <= mode ? down_val : up_val;
    end

endmodule

// File: rtl/mod13_counter_ctrl.sv
// mod13_counter_ctrl: round-robin two-port command sequencer driving a mod-13 counter.
// Ports: clk, rst_n (async active-low);
//        reqN_valid/reqN_op/reqN_arg in, reqN_ready out (N = 0,1; ready combinational);
//        count[3:0] current value, busy (not IDLE), owner (requester of current/last
//        command), done (one-cycle completion pulse), err (one-cycle rejected-LOAD pulse).
// Option: define MOD13_CTRL_LOADCHK_EN to reject LOAD values above 12 (count kept,
//         err pulses alongside done); otherwise err is tied 0 and LOAD is unchecked.
module mod13_counter_ctrl
    import mod13_ctrl_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [LEN_W-1:0] req0_arg,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [LEN_W-1:0] req1_arg,
    output logic             req1_ready,
    output logic [3:0]       count,
    output logic             busy,
    output logic             owner,
    output logic             done,
    output logic             err
);

    state_t           state;
    state_t           next_state;
    state_t           hs_state;
    op_t              op_r;
    op_t              op_in;
    logic [3:0]       data_r;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] arg_in;
    logic             last_served;
    logic             grant0;
    logic             grant1;
    logic             hs;
    logic             load_ok;

    // req0 wins unless req1 is also valid and req0 was the last one served.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_served);
        grant1     = req1_valid & ~grant0;
        req0_ready = (state == ST_IDLE) & grant0;
        req1_ready = (state == ST_IDLE) & grant1;
        hs         = req0_ready | req1_ready;
        op_in      = op_t'(grant1 ? req1_op : req0_op);
        arg_in     = grant1 ? req1_arg : req0_arg;
        hs_state   = (op_in == OP_LOAD) ? ST_LOAD :
                     ((op_in == OP_HOLD) || (arg_in == '0)) ? ST_DONE : ST_RUN;
        next_state = (state == ST_IDLE) ? (hs ? hs_state : ST_IDLE) :
                     (state == ST_LOAD) ? ST_DONE :
                     (state == ST_RUN)  ? ((remaining == LEN_W'(1)) ? ST_DONE : ST_RUN) :
                     ST_IDLE;
        busy       = state != ST_IDLE;
        done       = state == ST_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_r        <= OP_HOLD;
            data_r      <= 4'd0;
            remaining   <= '0;
            owner       <= 1'b0;
            last_served <= 1'b1;
        end else begin
            state <= next_state;
            if (hs) begin
                op_r        <= op_in;
                data_r      <= arg_in[3:0];
                remaining   <= arg_in;
                owner       <= grant1;
                last_served <= grant1;
            end else if (state == ST_RUN) begin
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

`ifdef MOD13_CTRL_LOADCHK_EN
    logic err_r;

    assign load_ok = data_r <= MOD_MAX;
    assign err     = err_r;

    // Registered from the LOAD cycle, so it lands exactly on the following DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_r <= 1'b0;
        else
            err_r <= (state == ST_LOAD) & ~load_ok;
    end
`else
    assign load_ok = 1'b1;
    assign err     = 1'b0;
`endif

    mod13_step_counter u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state == ST_RUN),
        .load    ((state == ST_LOAD) & load_ok),
        .mode    (op_r == OP_DOWN),
        .data_in (data_r),
        .count   (count)
    );

endmodule

// File: tb/tb_mod13_counter_ctrl.sv
// tb_mod13_counter_ctrl: vector table, random commands vs. modular-arithmetic model,
// plus hand sequences for mid-run reset and round-robin ties.
module tb_mod13_counter_ctrl;
    import mod13_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0] req0_op = 2'b11, req1_op = 2'b11;
    logic [7:0] req0_arg = 8'd0, req1_arg = 8'd0;
    logic       req0_ready, req1_ready;
    logic [3:0] count;
    logic       busy, owner, done, err;

    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt = 0;

    typedef struct {
        int         who;
        logic [1:0] op;
        logic [7:0] arg;
        int         cnt;
        int         lat;
    } vec_t;

    vec_t tbl[12];

    mod13_counter_ctrl #(.LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_arg(req0_arg), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_arg(req1_arg), .req1_ready(req1_ready),
        .count(count), .busy(busy), .owner(owner), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int step(input int c, input logic down);
        if (down) return (c == 0) ? 12 : c - 1;
        return (c == 12) ? 0 : (c + 1) % 16;
    endfunction

    task automatic cmd(input int who, input logic [1:0] op, input logic [7:0] arg,
                       input int exp_cnt, input int exp_lat, input int exp_err);
        int  t;
        int  lat;
        int  c;
        logic run;
        run = (op == OP_UP) || (op == OP_DOWN);
        c = m_cnt;
        @(negedge clk);
        if (who == 0) begin req0_valid = 1'b1; req0_op = op; req0_arg = arg; end
        else          begin req1_valid = 1'b1; req1_op = op; req1_arg = arg; end
        #1;
        t = 0;
        while (!(who == 0 ? req0_ready : req1_ready) && t < 20) begin
            @(negedge clk); #1; t++;
        end
        if (t == 20) begin
            chk("ready_timeout", 0, 1);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (lat < 300) begin
            if (run && lat >= 1) begin
                c = step(c, op == OP_DOWN);
                chk("step_count", count, c);
            end
            if (done) break;
            lat++;
            @(negedge clk);
        end
        chk("done_latency", lat, exp_lat);
        chk("final_count", count, exp_cnt);
        chk("owner", owner, who);
        chk("err_at_done", err, exp_err);
        chk("busy_at_done", busy, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("err_one_cycle", err, 0);
        chk("idle_after_done", busy, 0);
        m_cnt = exp_cnt;
    endtask

    initial begin
        int who, op, arg, ec, el;
        int t, ngrant, bad_grant, saw_done;
        tbl[0]  = '{0, OP_LOAD, 8'd7,  7,  1};
        tbl[1]  = '{0, OP_LOAD, 8'd10, 10, 1};
        tbl[2]  = '{0, OP_UP,   8'd5,  2,  5};
        tbl[3]  = '{1, OP_LOAD, 8'd1,  1,  1};
        tbl[4]  = '{1, OP_DOWN, 8'd3,  11, 3};
        tbl[5]  = '{0, OP_HOLD, 8'd9,  11, 0};
        tbl[6]  = '{1, OP_UP,   8'd0,  11, 0};
        tbl[7]  = '{0, OP_DOWN, 8'd13, 11, 13};
        tbl[8]  = '{1, OP_UP,   8'd26, 11, 26};
        tbl[9]  = '{0, OP_LOAD, 8'd12, 12, 1};
        tbl[10] = '{1, OP_UP,   8'd1,  0,  1};
        tbl[11] = '{0, OP_DOWN, 8'd1,  12, 1};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_owner", owner, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("idle_no_valid_ready", {req0_ready, req1_ready}, 0);

        for (int i = 0; i < 12; i++)
            cmd(tbl[i].who, tbl[i].op, tbl[i].arg, tbl[i].cnt, tbl[i].lat, 0);

        cmd(0, OP_LOAD, 8'd3, 3, 1, 0);
`ifdef MOD13_CTRL_LOADCHK_EN
        cmd(1, OP_LOAD, 8'd14, 3, 1, 1);
        cmd(0, OP_UP, 8'd2, 5, 2, 0);
`else
        cmd(1, OP_LOAD, 8'd14, 14, 1, 0);
        cmd(0, OP_UP, 8'd2, 0, 2, 0);
`endif

        for (int i = 0; i < 30; i++) begin
            who = $urandom_range(0, 1);
            op  = $urandom_range(0, 3);
            arg = (op == 0) ? $urandom_range(0, 12) : $urandom_range(0, 30);
            case (op)
                0:       begin ec = arg;                              el = 1;   end
                1:       begin ec = (m_cnt + arg) % 13;               el = arg; end
                2:       begin ec = (m_cnt + 13 - (arg % 13)) % 13;   el = arg; end
                default: begin ec = m_cnt;                            el = 0;   end
            endcase
            cmd(who, 2'(op), 8'(arg), ec, el, 0);
        end

        // Reset in the middle of UP 20, right after the 4th step.
        cmd(1, OP_LOAD, 8'd5, 5, 1, 0);
        @(negedge clk);
        req0_valid = 1'b1; req0_op = OP_UP; req0_arg = 8'd20;
        #1;
        t = 0;
        while (!req0_ready && t < 20) begin @(negedge clk); #1; t++; end
        chk("midrun_ready", int'(t < 20), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrun_step4", count, 9);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_count", count, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_owner", owner, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("midrun_no_done", saw_done, 0);
        m_cnt = 0;

        // Both requesters continuously valid with HOLD: grants must alternate starting with req0.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = OP_HOLD;
        req1_valid = 1'b1; req1_op = OP_HOLD;
        ngrant = 0;
        bad_grant = 0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            #1;
            if (req0_ready && req1_ready) bad_grant++;
            if (req0_ready || req1_ready) begin
                chk("tie_winner", int'(req1_ready), ngrant % 2);
                chk("tie_spacing", cyc, 2 * ngrant);
                ngrant++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("tie_grant_count", ngrant, 5);
        chk("tie_both_ready", bad_grant, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
